// File: rtl/ser_feed_if.sv
// Parallel-word handshake and serial-output bundle for ser_feed.
interface ser_feed_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_start;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, word_start, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, word_start, busy
    );
endinterface

// File: rtl/ser_feed.sv
// Word-to-bit serializer with a one-word holding buffer and optional idle gap between words.
// Define SER_FEED_LSB_FIRST_EN to shift LSB first; default is MSB first.
module ser_feed #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input logic        clk,
    input logic        rst,
    ser_feed_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] LastBit = BW'(WIDTH - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_start_q, word_start_d;

    logic [WIDTH-1:0] sreg_shifted;
    logic             cur_bit;
    logic             load_word;

    // sreg is kept all-zero outside SHIFT, so its output bit doubles as ser_out.
`ifdef SER_FEED_LSB_FIRST_EN
    assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    assign cur_bit      = sreg_q[0];
`else
    assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    assign cur_bit      = sreg_q[WIDTH-1];
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        sreg_d       = sreg_q;
        bcnt_d       = bcnt_q;
        gcnt_d       = gcnt_q;
        ser_valid_d  = 1'b0;
        word_start_d = 1'b0;
        load_word    = 1'b0;

        if (bus.din_valid && !hold_full_q) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    load_word = 1'b1;
                end
            end
            StShift: begin
                if (bcnt_q != LastBit) begin
                    sreg_d      = sreg_shifted;
                    bcnt_d      = bcnt_q + BW'(1);
                    ser_valid_d = 1'b1;
                end else begin
                    sreg_d = '0;
                    bcnt_d = '0;
                    if (GAP > 0) begin
                        state_d = StGap;
                        gcnt_d  = GW'(GAP);
                    end else if (hold_full_q) begin
                        load_word = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gcnt_q <= GW'(1)) begin
                    gcnt_d = '0;
                    if (hold_full_q) begin
                        load_word = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                sreg_d  = '0;
            end
        endcase

        // Never coincides with an accept: accept needs hold empty, load needs it full.
        if (load_word) begin
            state_d      = StShift;
            sreg_d       = hold_q;
            hold_full_d  = 1'b0;
            bcnt_d       = '0;
            ser_valid_d  = 1'b1;
            word_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sreg_q       <= '0;
            bcnt_q       <= '0;
            gcnt_q       <= '0;
            ser_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            sreg_q       <= sreg_d;
            bcnt_q       <= bcnt_d;
            gcnt_q       <= gcnt_d;
            ser_valid_q  <= ser_valid_d;
            word_start_q <= word_start_d;
        end
    end

    assign bus.din_ready  = !hold_full_q;
    assign bus.ser_out    = cur_bit;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.word_start = word_start_q;
    assign bus.busy       = (state_q != StIdle) || hold_full_q;
endmodule

// File: tb/tb_ser_feed.sv
// Scoreboard bench for ser_feed: one instance with GAP=0, one with GAP=3.
module tb_ser_feed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ser_feed_if #(.WIDTH(8)) bus0 ();
    ser_feed_if #(.WIDTH(8)) bus1 ();

    ser_feed #(.WIDTH(8), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ser_feed #(.WIDTH(8), .GAP(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Each entry: {word_start, bit}
    logic [1:0] sb0[$];
    logic [1:0] sb1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int k);
`ifdef SER_FEED_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    // Monitor: pops expected bits whenever a DUT presents a data bit.
    logic [1:0] e0, e1;
    always @(negedge clk) begin
        if (bus0.ser_valid === 1'b1) begin
            if (sb0.size() == 0) check("dut0 unexpected bit", 32'(bus0.ser_valid), 32'd0);
            else begin
                e0 = sb0.pop_front();
                check("dut0 bit", 32'({bus0.word_start, bus0.ser_out}), 32'(e0));
            end
        end else begin
            check("dut0 idle outputs", 32'({bus0.word_start, bus0.ser_out}), 32'd0);
        end
        if (bus1.ser_valid === 1'b1) begin
            if (sb1.size() == 0) check("dut1 unexpected bit", 32'(bus1.ser_valid), 32'd0);
            else begin
                e1 = sb1.pop_front();
                check("dut1 bit", 32'({bus1.word_start, bus1.ser_out}), 32'(e1));
            end
        end else begin
            check("dut1 idle outputs", 32'({bus1.word_start, bus1.ser_out}), 32'd0);
        end
    end

    // Present a word and wait for acceptance; leaves din_valid high for back-to-back use.
    task automatic send(input int which, input logic [7:0] w, output int acc);
        logic rdy;
        bit   ok;
        ok  = 0;
        acc = -1;
        rdy = 1'b0;
        @(posedge clk);
        #1;
        if (which == 0) begin bus0.din = w; bus0.din_valid = 1'b1; end
        else            begin bus1.din = w; bus1.din_valid = 1'b1; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            rdy = (which == 0) ? bus0.din_ready : bus1.din_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                ok  = 1;
                acc = cyc;
                for (int k = 0; k < 8; k++) begin
                    if (which == 0) sb0.push_back({k == 0, exp_bit(w, k)});
                    else            sb1.push_back({k == 0, exp_bit(w, k)});
                end
            end
        end
        if (!ok) check("accept timeout", 32'(rdy), 32'd1);
    endtask

    task automatic wait_start(input int which, output int c);
        logic ws;
        c  = -1;
        ws = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ws = (which == 0) ? bus0.word_start : bus1.word_start;
            if (ws === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("word_start timeout", 32'(ws), 32'd1);
    endtask

    int acc, a2, a3, c;
    logic [23:0] vmask, wmask;
    logic [18:0] gv, gw;

    initial begin
        bus0.din = '0; bus0.din_valid = 1'b0;
        bus1.din = '0; bus1.din_valid = 1'b0;

        // Asynchronous reset mid-cycle, then idle
        #2 rst = 1'b0;
        #1;
        check("dut0 reset outputs", 32'({bus0.ser_valid, bus0.ser_out, bus0.word_start,
                                         bus0.din_ready, bus0.busy}), 32'b00010);
        check("dut1 reset outputs", 32'({bus1.ser_valid, bus1.ser_out, bus1.word_start,
                                         bus1.din_ready, bus1.busy}), 32'b00010);
        #24 rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("dut0 idle ready/busy", 32'({bus0.din_ready, bus0.busy}), 32'b10);
            check("dut1 idle ready/busy", 32'({bus1.din_ready, bus1.busy}), 32'b10);
        end

        // Single word, GAP=0
        send(0, 8'hB4, acc);
        bus0.din_valid = 1'b0;
        wait_start(0, c);
        check("dut0 single latency", 32'(c - acc), 32'd1);
        check("dut0 busy while shifting", 32'(bus0.busy), 32'd1);
        repeat (12) @(negedge clk);
        check("dut0 valid after word", 32'(bus0.ser_valid), 32'd0);
        check("dut0 single drained", 32'(sb0.size()), 32'd0);

        // Back-to-back burst, GAP=0
        vmask = '0;
        wmask = '0;
        fork
            begin
                send(0, 8'hB4, acc);
                send(0, 8'h2D, a2);
                send(0, 8'hFF, a3);
                bus0.din_valid = 1'b0;
            end
            begin
                wait_start(0, c);
                for (int i = 0; i < 24; i++) begin
                    if (i > 0) @(negedge clk);
                    vmask = {vmask[22:0], bus0.ser_valid};
                    wmask = {wmask[22:0], bus0.word_start};
                end
                @(negedge clk);
                check("burst valid after end", 32'(bus0.ser_valid), 32'd0);
            end
        join
        check("burst latency", 32'(c - acc), 32'd1);
        check("burst valid run", 32'(vmask), 32'hFF_FFFF);
        check("burst word_start", 32'(wmask), 32'h80_8080);
        check("burst drained", 32'(sb0.size()), 32'd0);

        // GAP=3, two words
        gv = '0;
        gw = '0;
        fork
            begin
                send(1, 8'hB4, acc);
                send(1, 8'hB4, a2);
                bus1.din_valid = 1'b0;
            end
            begin
                wait_start(1, c);
                for (int i = 0; i < 19; i++) begin
                    if (i > 0) @(negedge clk);
                    gv = {gv[17:0], bus1.ser_valid};
                    gw = {gw[17:0], bus1.word_start};
                end
            end
        join
        check("gap latency", 32'(c - acc), 32'd1);
        check("gap valid pattern", 32'(gv), 32'h7_F8FF);
        check("gap word_start", 32'(gw), 32'h4_0080);
        repeat (5) @(negedge clk);
        check("gap drained", 32'(sb1.size()), 32'd0);

        // Reset after bit 4 with a word buffered
        send(0, 8'hB4, acc);
        send(0, 8'h2D, a2);
        bus0.din_valid = 1'b0;
        repeat (acc + 5 - cyc) @(posedge clk);
        @(negedge clk);
        check("dut0 busy before reset", 32'(bus0.busy), 32'd1);
        #2 rst = 1'b0;
        sb0.delete();
        #1;
        check("dut0 mid-word reset", 32'({bus0.ser_valid, bus0.ser_out, bus0.word_start,
                                          bus0.din_ready, bus0.busy}), 32'b00010);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        send(0, 8'h5A, acc);
        bus0.din_valid = 1'b0;
        wait_start(0, c);
        check("post-reset latency", 32'(c - acc), 32'd1);
        repeat (12) @(negedge clk);
        check("post-reset valid low", 32'(bus0.ser_valid), 32'd0);
        check("post-reset drained", 32'(sb0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
